// File: rtl/alu_op_dispatcher_pkg.sv
// Shared types and constants for the ALU operation dispatcher.
package alu_dispatch_pkg;

    // Dispatcher control state.
    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Unit codes of the default four-unit build.
    localparam int FUN_ARITH = 0;
    localparam int FUN_LOGIC = 1;
    localparam int FUN_CMP   = 2;
    localparam int FUN_SHIFT = 3;

    // Bits needed for a counter that must reach max_count without wrapping.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/alu_op_dispatcher_if.sv
// Op handshake and unit enable/done bus between ALU control and the dispatcher.
interface alu_op_dispatcher_if #(
    parameter int FUN_W     = 2,
    parameter int NUM_UNITS = 4
);
    logic [FUN_W-1:0]     ALU_FUN;
    logic                 OP_Valid;
    logic                 OP_Ready;
    logic [NUM_UNITS-1:0] Unit_Enable;
    logic [NUM_UNITS-1:0] Unit_Done;
    logic                 OP_Done;
    logic                 OP_Error;
    logic                 Busy;

    // ALU control side plus the execution units' done lines.
    modport master (
        output ALU_FUN, OP_Valid, Unit_Done,
        input  OP_Ready, Unit_Enable, OP_Done, OP_Error, Busy
    );

    // Dispatcher side.
    modport slave (
        input  ALU_FUN, OP_Valid, Unit_Done,
        output OP_Ready, Unit_Enable, OP_Done, OP_Error, Busy
    );
endinterface

// File: rtl/alu_op_dispatcher_onehot_decoder.sv
// Combinational code-to-one-hot decoder with a flag for codes that map to a unit.
module onehot_decoder #(
    parameter int IN_W  = 2,
    parameter int OUT_N = 4
) (
    input  logic [IN_W-1:0]  code,
    output logic [OUT_N-1:0] onehot,
    output logic             legal
);

    // Codes at or beyond OUT_N give an all-zero vector and legal=0.
    always_comb begin
        onehot = '0;
        legal  = 1'b0;
        for (int k = 0; k < OUT_N; k++) begin
            if (code == IN_W'(k)) begin
                onehot[k] = 1'b1;
                legal     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Dispatches one ALU op at a time to its execution unit and waits for its done,
// giving up after TIMEOUT_CYC enable cycles.
module alu_op_dispatcher
    import alu_dispatch_pkg::*;
#(
    parameter int FUN_W       = 2,
    parameter int NUM_UNITS   = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input logic              CLK,
    input logic              RST,
    alu_op_dispatcher_if.slave bus
);

    localparam int             CNT_W    = cnt_width(TIMEOUT_CYC);
    // Counter value seen at the edge closing the last allowed enable cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e               state;
    logic [CNT_W-1:0]     cnt;
    logic [FUN_W-1:0]     code_q;
    logic [NUM_UNITS-1:0] en_q;
    logic                 done_q;
    logic                 err_q;
    logic                 busy_q;

    logic [NUM_UNITS-1:0] dec_onehot;
    logic                 dec_legal;
    logic                 sel_done;

    onehot_decoder #(
        .IN_W  (FUN_W),
        .OUT_N (NUM_UNITS)
    ) u_dec (
        .code   (bus.ALU_FUN),
        .onehot (dec_onehot),
        .legal  (dec_legal)
    );

    // Only the latched unit's done counts; the others are ignored.
    assign sel_done = bus.Unit_Done[code_q];

    assign bus.OP_Ready    = (state == IDLE);
    assign bus.Unit_Enable = en_q;
    assign bus.OP_Done     = done_q;
    assign bus.OP_Error    = err_q;
    assign bus.Busy        = busy_q;

    // Control FSM: accept in IDLE, hold the enable in EXEC until done or timeout.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            code_q <= '0;
            en_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.OP_Valid) begin
                        if (dec_legal) begin
                            code_q <= bus.ALU_FUN;
                            cnt    <= '0;
                            en_q   <= dec_onehot;
                            busy_q <= 1'b1;
                            state  <= EXEC;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // Done is tested first so a done on the last cycle wins.
                    if (sel_done) begin
                        en_q   <= '0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        en_q   <= '0;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: begin
                    en_q   <= '0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Directed bench for alu_op_dispatcher: a default build (4 units, timeout 15)
// and a reduced build (3 units, timeout 4) share one clock and reset.
module tb_alu_op_dispatcher;
    import alu_dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_op_dispatcher_if #(.FUN_W(2), .NUM_UNITS(4)) ifa ();
    alu_op_dispatcher_if #(.FUN_W(2), .NUM_UNITS(3)) ifb ();

    alu_op_dispatcher #(.FUN_W(2), .NUM_UNITS(4), .TIMEOUT_CYC(15)) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (ifa)
    );

    alu_op_dispatcher #(.FUN_W(2), .NUM_UNITS(3), .TIMEOUT_CYC(4)) dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (ifb)
    );

    typedef struct {
        logic done;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic d, input logic e);
        exp_t x;
        x.done = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Pop the oldest expected outcome and compare it with the chosen DUT's pulses.
    task automatic sb_check(input string tag, input bit use_b);
        exp_t x;
        logic [1:0] obs;
        obs = use_b ? {ifb.OP_Done, ifb.OP_Error} : {ifa.OP_Done, ifa.OP_Error};
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=scoreboard_empty expected=pending_entry", tag);
        end else begin
            x = sb.pop_front();
            chk(tag, {30'd0, obs}, {30'd0, x.done, x.err});
        end
    endtask

    // Enable must stay one-hot or zero and the two pulses must never coincide.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert ($onehot0(ifa.Unit_Enable) && !(ifa.OP_Done && ifa.OP_Error)
                    && $onehot0(ifb.Unit_Enable) && !(ifb.OP_Done && ifb.OP_Error)) else begin
                errors++;
                $error("FAIL invariant observed=a_en%b/%b%b b_en%b/%b%b expected=onehot0_and_exclusive",
                       ifa.Unit_Enable, ifa.OP_Done, ifa.OP_Error,
                       ifb.Unit_Enable, ifb.OP_Done, ifb.OP_Error);
            end
        end
    end

    initial begin
        rst = 1'b1;
        ifa.ALU_FUN = '0; ifa.OP_Valid = 1'b0; ifa.Unit_Done = '0;
        ifb.ALU_FUN = '0; ifb.OP_Valid = 1'b0; ifb.Unit_Done = '0;

        // Reset for two edges, then release.
        tick();
        tick();
        chk("rst_en_a", ifa.Unit_Enable, 4'b0000);
        chk("rst_busy_a", ifa.Busy, 1'b0);
        chk("rst_pulses_a", {ifa.OP_Done, ifa.OP_Error}, 2'b00);
        chk("rst_en_b", ifb.Unit_Enable, 3'b000);
        rst = 1'b0;
        tick();
        chk("idle_ready_a", ifa.OP_Ready, 1'b1);
        chk("idle_ready_b", ifb.OP_Ready, 1'b1);
        chk("idle_en_a", ifa.Unit_Enable, 4'b0000);
        chk("idle_pulses_a", {ifa.OP_Done, ifa.OP_Error}, 2'b00);

        // Legal op on unit 2, done at cycle 3; ALU_FUN changes during EXEC are ignored.
        ifa.ALU_FUN = 2'(FUN_CMP); ifa.OP_Valid = 1'b1; sb_push(1'b1, 1'b0);
        tick();
        ifa.OP_Valid = 1'b0; ifa.ALU_FUN = 2'(FUN_ARITH);
        chk("legal_c1_en", ifa.Unit_Enable, 4'b0100);
        chk("legal_c1_busy", ifa.Busy, 1'b1);
        chk("legal_c1_ready", ifa.OP_Ready, 1'b0);
        tick();
        chk("legal_c2_en", ifa.Unit_Enable, 4'b0100);
        ifa.ALU_FUN = 2'(FUN_LOGIC); ifa.OP_Valid = 1'b1;
        tick();
        ifa.OP_Valid = 1'b0;
        chk("legal_c3_en", ifa.Unit_Enable, 4'b0100);
        ifa.Unit_Done = 4'b0100;
        tick();
        ifa.Unit_Done = 4'b0000;
        sb_check("legal_c4_done", 1'b0);
        chk("legal_c4_en", ifa.Unit_Enable, 4'b0000);
        chk("legal_c4_ready", ifa.OP_Ready, 1'b1);
        chk("legal_c4_busy", ifa.Busy, 1'b0);
        tick();
        chk("legal_c5_pulses", {ifa.OP_Done, ifa.OP_Error}, 2'b00);

        // Illegal code 3 on the three-unit build.
        ifb.ALU_FUN = 2'b11; ifb.OP_Valid = 1'b1; sb_push(1'b0, 1'b1);
        tick();
        ifb.OP_Valid = 1'b0;
        sb_check("illegal_err", 1'b1);
        chk("illegal_en", ifb.Unit_Enable, 3'b000);
        chk("illegal_ready", ifb.OP_Ready, 1'b1);
        chk("illegal_busy", ifb.Busy, 1'b0);
        tick();
        chk("illegal_pulse_len", ifb.OP_Error, 1'b0);

        // Timeout after exactly four enable cycles.
        ifb.ALU_FUN = 2'b00; ifb.OP_Valid = 1'b1; sb_push(1'b0, 1'b1);
        tick();
        ifb.OP_Valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tmo_en_c%0d", i), ifb.Unit_Enable, 3'b001);
            tick();
        end
        sb_check("tmo_err", 1'b1);
        chk("tmo_en_off", ifb.Unit_Enable, 3'b000);
        tick();
        chk("tmo_pulse_len", ifb.OP_Error, 1'b0);

        // Done on the fourth (last allowed) enable cycle counts as success.
        ifb.ALU_FUN = 2'b00; ifb.OP_Valid = 1'b1; sb_push(1'b1, 1'b0);
        tick();
        ifb.OP_Valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("last_en_c%0d", i), ifb.Unit_Enable, 3'b001);
            tick();
        end
        chk("last_en_c4", ifb.Unit_Enable, 3'b001);
        ifb.Unit_Done = 3'b001;
        tick();
        ifb.Unit_Done = 3'b000;
        sb_check("last_done", 1'b1);
        chk("last_en_off", ifb.Unit_Enable, 3'b000);

        // Wrong-unit done is ignored; next op accepted in the OP_Done cycle.
        ifa.ALU_FUN = 2'(FUN_LOGIC); ifa.OP_Valid = 1'b1; sb_push(1'b1, 1'b0);
        tick();
        ifa.OP_Valid = 1'b0;
        chk("wrong_c1_en", ifa.Unit_Enable, 4'b0010);
        ifa.Unit_Done = 4'b1000;
        tick();
        chk("wrong_c2_en", ifa.Unit_Enable, 4'b0010);
        chk("wrong_c2_pulses", {ifa.OP_Done, ifa.OP_Error}, 2'b00);
        ifa.Unit_Done = 4'b0010;
        tick();
        ifa.Unit_Done = 4'b0000;
        sb_check("b2b_first_done", 1'b0);
        chk("b2b_ready_in_done", ifa.OP_Ready, 1'b1);
        chk("b2b_gap_en", ifa.Unit_Enable, 4'b0000);
        ifa.ALU_FUN = 2'(FUN_SHIFT); ifa.OP_Valid = 1'b1; sb_push(1'b1, 1'b0);
        tick();
        ifa.OP_Valid = 1'b0;
        chk("b2b_second_en", ifa.Unit_Enable, 4'b1000);
        ifa.Unit_Done = 4'b1000;
        tick();
        ifa.Unit_Done = 4'b0000;
        sb_check("b2b_min_latency_done", 1'b0);
        chk("b2b_second_en_off", ifa.Unit_Enable, 4'b0000);

        // Default-build timeout: error expected 16 cycles after accept.
        ifa.ALU_FUN = 2'(FUN_SHIFT); ifa.OP_Valid = 1'b1; sb_push(1'b0, 1'b1);
        tick();
        ifa.OP_Valid = 1'b0;
        lat = 1;
        while (!(ifa.OP_Done || ifa.OP_Error) && lat < 40) begin
            tick();
            lat++;
        end
        sb_check("tmo15_err", 1'b0);
        chk("tmo15_latency", lat, 16);
        chk("tmo15_en_off", ifa.Unit_Enable, 4'b0000);

        // Reset on the second enable cycle drops the enable with no pulse.
        tick();
        ifa.ALU_FUN = 2'(FUN_CMP); ifa.OP_Valid = 1'b1;
        tick();
        ifa.OP_Valid = 1'b0;
        chk("rstx_c1_en", ifa.Unit_Enable, 4'b0100);
        tick();
        chk("rstx_c2_en", ifa.Unit_Enable, 4'b0100);
        rst = 1'b1;
        tick();
        chk("rstx_en", ifa.Unit_Enable, 4'b0000);
        chk("rstx_pulses", {ifa.OP_Done, ifa.OP_Error}, 2'b00);
        chk("rstx_busy", ifa.Busy, 1'b0);
        rst = 1'b0;
        tick();
        chk("rstx_ready", ifa.OP_Ready, 1'b1);
        chk("rstx_after_pulses", {ifa.OP_Done, ifa.OP_Error}, 2'b00);
        chk("rstx_after_en", ifa.Unit_Enable, 4'b0000);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
